peridot_phy_rxd: RTL and testbench

UART receiver PHY for the PERIDOT serial path: recovers 8N1 frames from the asynchronous `rxd` line and presents each received byte on an Avalon-ST source with valid/ready handshake. It is the receive-side counterpart of the PERIDOT UART sender PHY, uses the same baud-divider parameterisation, and sits between the board UART pin and the packet/command layer.

---
 rtl/peridot_phy_rxd.sv | 187 ++++++++++++++++++
 tb/tb_peridot_phy_rxd.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/peridot_phy_rxd.sv
// peridot_phy_rxd
// UART receiver PHY for the PERIDOT serial path. Recovers 8N1 frames from the
// asynchronous rxd line and presents each received byte on an Avalon-ST
// source (valid/ready) through a single holding register.
//
// Parameters:
//   CLOCK_FREQUENCY  clock frequency in Hz
//   UART_BAUDRATE    line rate in bit/s; N = CLOCK_FREQUENCY/UART_BAUDRATE (4..4096)
// Ports:
//   clk          single clock, rising edge
//   reset_n      asynchronous active-low reset
//   rxd          UART line, idle high, asynchronous to clk
//   out_ready    sink accepts byte
//   out_valid    byte held on out_data
//   out_data     received byte, LSB = first data bit
//   frame_error  one-cycle pulse: stop bit sampled 0
//   overrun      one-cycle pulse: byte lost because holding register full
//
// Build option:
//   PERIDOT_RXD_NOISEFILTER_EN  when defined, the line is the 2-of-3 majority
//   of the last three synchronizer outputs (rejects single-clock glitches,
//   adds one clock of pin-to-line latency).
module peridot_phy_rxd #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int UART_BAUDRATE   = 115200
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rxd,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       frame_error,
    output logic       overrun
);

    localparam int          N        = CLOCK_FREQUENCY / UART_BAUDRATE;
    localparam logic [11:0] DIV_HALF = 12'(N / 2 - 1);
    localparam logic [11:0] DIV_FULL = 12'(N - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t      state;
    logic [11:0] divcount;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_reg;
    logic        sync_p0;
    logic        sync_p1;
    logic        rx_line;
    logic        accept;

    // Synchronizer stages; reset to the idle (high) line level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= rxd;
            sync_p1 <= sync_p0;
        end
    end

`ifdef PERIDOT_RXD_NOISEFILTER_EN
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic hist_p2;
    logic hist_p3;

    // History of the synchronizer output for the majority vote.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_p2 <= 1'b1;
            hist_p3 <= 1'b1;
        end else begin
            hist_p2 <= sync_p1;
            hist_p3 <= hist_p2;
        end
    end

    assign rx_line = majority3(sync_p1, hist_p2, hist_p3);
`else
    assign rx_line = sync_p1;
`endif

    assign accept = out_valid & out_ready;

    // Data shift register: only meaningful once a full frame has been shifted,
    // so it carries no reset.
    always_ff @(posedge clk) begin
        if (state == ST_DATA && divcount == 12'd0) begin
            shift_reg <= {rx_line, shift_reg[7:1]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            divcount    <= 12'd0;
            bit_idx     <= 3'd0;
            out_valid   <= 1'b0;
            out_data    <= 8'h00;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_error <= 1'b0;
            overrun     <= 1'b0;
            // Accepted byte leaves the holding register unless a new byte
            // is loaded below in the same cycle.
            if (accept) begin
                out_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (!rx_line) begin
                        divcount <= DIV_HALF;
                        state    <= ST_START;
                    end
                end

                ST_START: begin
                    if (divcount == 12'd0) begin
                        if (!rx_line) begin
                            divcount <= DIV_FULL;
                            bit_idx  <= 3'd0;
                            state    <= ST_DATA;
                        end else begin
                            // Start bit did not survive to mid-bit: false start.
                            state <= ST_IDLE;
                        end
                    end else begin
                        divcount <= divcount - 12'd1;
                    end
                end

                ST_DATA: begin
                    if (divcount == 12'd0) begin
                        divcount <= DIV_FULL;
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                        end
                    end else begin
                        divcount <= divcount - 12'd1;
                    end
                end

                ST_STOP: begin
                    if (divcount == 12'd0) begin
                        if (rx_line) begin
                            if (!out_valid || out_ready) begin
                                out_data  <= shift_reg;
                                out_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                            state <= ST_IDLE;
                        end else begin
                            frame_error <= 1'b1;
                            state       <= ST_BREAK;
                        end
                    end else begin
                        divcount <= divcount - 12'd1;
                    end
                end

                ST_BREAK: begin
                    // Line held low past the stop bit: wait for it to idle.
                    if (rx_line) begin
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_peridot_phy_rxd.sv
// Testbench for peridot_phy_rxd with N = 8 (1 MHz clock, 125 kbit/s).
// Stimulus pushes expected events (byte / frame error / overrun with the
// cycle they must appear in) into a queue; a monitor process pops and
// compares whenever the DUT presents one.
module tb_peridot_phy_rxd;

    localparam int CLK_HZ = 1000000;
    localparam int BAUD   = 125000;
`ifdef PERIDOT_RXD_NOISEFILTER_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    // Pin edge before posedge P+1 -> T0 = P+LAT+1; outputs seen after edge T0+76.
    localparam int EVT_OFS = LAT + 1 + 76;

    localparam int K_DATA = 0;
    localparam int K_FERR = 1;
    localparam int K_OVR  = 2;

    logic       clk;
    logic       reset_n;
    logic       rxd;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       frame_error;
    logic       overrun;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    peridot_phy_rxd #(
        .CLOCK_FREQUENCY(CLK_HZ),
        .UART_BAUDRATE  (BAUD)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rxd        (rxd),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .frame_error(frame_error),
        .overrun    (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_event(input int kind, input logic [7:0] data);
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event actual=kind%0d data=%0h required=none (cycle %0d)",
                     kind, data, cyc);
        end else begin
            e = sbq.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_cycle", cyc, e.cyc);
            if (e.kind == K_DATA) chk("out_data", data, e.data);
        end
    endtask

    // Monitor: new byte = out_valid rising or reloaded right after a handshake.
    initial begin
        logic       pv;
        logic       pa;
        logic [7:0] pd;
        pv = 1'b0;
        pa = 1'b0;
        pd = 8'h00;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (out_valid && (!pv || pa)) check_event(K_DATA, out_data);
                if (pv && !pa && out_valid) chk("hold_stable", out_data, pd);
                if (frame_error) check_event(K_FERR, 8'h00);
                if (overrun) check_event(K_OVR, 8'h00);
                if (sbq.size() > 0 && cyc > sbq[0].cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_event actual=none required=kind%0d by cycle %0d",
                             sbq[0].kind, sbq[0].cyc);
                    void'(sbq.pop_front());
                end
            end
            pv = out_valid;
            pa = out_valid && out_ready;
            pd = out_data;
        end
    end

    // Sends one 8N1 frame starting at a negedge; gl = bit slot (0 = start)
    // that gets a one-clock low glitch at mid-bit, -1 for none.
    task automatic send_frame(input logic [7:0] d, input logic stopv, input int gl, input int kind);
        logic [9:0] bits;
        exp_t       e;
        bits = {stopv, d, 1'b0};
        if (kind >= 0) begin
            e.kind = kind;
            e.data = d;
            e.cyc  = cyc + EVT_OFS;
            sbq.push_back(e);
        end
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 8; j++) begin
                rxd = (i == gl && j == 4) ? 1'b0 : bits[i];
                @(negedge clk);
            end
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        rxd       = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_frame_error", frame_error, 0);
        chk("reset_overrun", overrun, 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Plain frame, sink always ready.
        send_frame(8'h55, 1'b1, -1, K_DATA);
        repeat (10) @(negedge clk);

        // False start: 2-clock low pulse, then a good frame.
        rxd = 1'b0;
        repeat (2) @(negedge clk);
        rxd = 1'b1;
        repeat (20) @(negedge clk);
        chk("false_start_no_valid", out_valid, 0);
        send_frame(8'hC3, 1'b1, -1, K_DATA);
        repeat (10) @(negedge clk);

        // Framing error followed by a break, then recovery.
        send_frame(8'h00, 1'b0, -1, K_FERR);
        rxd = 1'b0;
        repeat (40) @(negedge clk);
        rxd = 1'b1;
        repeat (10) @(negedge clk);
        send_frame(8'h81, 1'b1, -1, K_DATA);
        repeat (10) @(negedge clk);

        // Overrun: sink stalled across two back-to-back frames.
        #1 out_ready = 1'b0;
        @(negedge clk);
        send_frame(8'hA5, 1'b1, -1, K_DATA);
        send_frame(8'h5A, 1'b1, -1, K_OVR);
        repeat (3) @(negedge clk);
        chk("ovr_held_valid", out_valid, 1);
        chk("ovr_held_data", out_data, 8'hA5);
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("accept_valid_falls", out_valid, 0);
        chk("accept_data_kept", out_data, 8'hA5);
        repeat (5) @(negedge clk);

        // Reset in the middle of the data bits of a frame.
        rxd = 1'b0;
        repeat (24) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_out_data", out_data, 0);
        chk("midreset_frame_error", frame_error, 0);
        chk("midreset_overrun", overrun, 0);
        rxd = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        send_frame(8'h3C, 1'b1, -1, K_DATA);
        repeat (10) @(negedge clk);

`ifdef PERIDOT_RXD_NOISEFILTER_EN
        // Glitch at mid-bit of data bit 3 (slot 4) must be filtered out.
        send_frame(8'hFF, 1'b1, 4, K_DATA);
        repeat (10) @(negedge clk);
`endif

        for (int k = 0; k < 200 && sbq.size() > 0; k++) @(negedge clk);
        while (sbq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=none required=kind%0d at cycle %0d",
                     sbq[0].kind, sbq[0].cyc);
            void'(sbq.pop_front());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
